fpu_cvt_to_int: RTL and testbench

//  Multi-cycle FP32 -> 32-bit integer converter implementing RISC-V FCVT.W.S / FCVT.WU.S.

---
 rtl/fpu_cvt_to_int.sv | 195 +++++++++++++++++++
 tb/tb_fpu_cvt_to_int.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_cvt_to_int
//  Description : Multi-cycle FP32 to 32-bit signed/unsigned integer converter
//                (FCVT.W.S / FCVT.WU.S) with IEEE rounding and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_cvt_to_int (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        is_unsigned_i,
   input  logic [2:0]  rounding_mode_i,
   input  logic [31:0] A_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] cvrt_to_int_out,
   output logic [4:0]  fflags_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ALIGN  = 3'd2,
      S_ROUND  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [2:0] c_RNE = 3'b000;
   localparam logic [2:0] c_RDN = 3'b010;
   localparam logic [2:0] c_RUP = 3'b011;
   localparam logic [2:0] c_RMM = 3'b100;

   state_t             r_state;
   logic [31:0]        r_a;
   logic               r_uns;
   logic [2:0]         r_rm;
   logic               r_sign;
   logic               r_nan;
   logic               r_inf;
   logic [23:0]        r_m;
   logic signed [9:0]  r_e;
   logic               r_big;
   logic [31:0]        r_int;
   logic               r_g;
   logic               r_s;
   logic [31:0]        r_res;
   logic               r_nv;
   logic               r_nx;

   logic signed [9:0]  w_e;
   logic [5:0]         w_sh;
   logic [55:0]        w_t;
   logic               w_inc;
   logic [32:0]        w_mag;
   logic [31:0]        w_res;
   logic               w_nv;
   logic               w_nx;

   assign w_e = $signed({2'b00, r_a[30:23]}) - 10'sd127;

   // Value = m * 2^(e-23); shifting by e+1 leaves the integer at [55:24] and guard at [23]
   assign w_sh = r_e[5:0] + 6'd1;
   assign w_t  = {32'd0, r_m} << w_sh;

   always_comb begin
      w_inc = 1'b0;
      case (r_rm)
         c_RNE:   w_inc = r_g & (r_s | r_int[0]);
         c_RDN:   w_inc = r_sign & (r_g | r_s);
         c_RUP:   w_inc = ~r_sign & (r_g | r_s);
         c_RMM:   w_inc = r_g;
         default: w_inc = 1'b0;
      endcase
   end

   assign w_mag = {1'b0, r_int} + {32'd0, w_inc};

   always_comb begin
      w_res = 32'd0;
      w_nv  = 1'b0;
      w_nx  = r_g | r_s;
      if (!r_uns) begin
         if ((r_big && !r_sign) || (!r_sign && w_mag > 33'h0_7FFF_FFFF)) begin
            w_res = 32'h7FFF_FFFF;
            w_nv  = 1'b1;
         end else if (r_big || w_mag > 33'h0_8000_0000) begin
            w_res = 32'h8000_0000;
            w_nv  = 1'b1;
         end else begin
            w_res = r_sign ? (32'd0 - w_mag[31:0]) : w_mag[31:0];
         end
      end else begin
         if ((r_big && !r_sign) || (!r_sign && w_mag[32])) begin
            w_res = 32'hFFFF_FFFF;
            w_nv  = 1'b1;
         end else if (r_big || (r_sign && w_mag != 33'd0)) begin
            w_res = 32'd0;
            w_nv  = 1'b1;
         end else begin
            w_res = r_sign ? 32'd0 : w_mag[31:0];
         end
      end
      if (w_nv) w_nx = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state         <= S_IDLE;
         r_a             <= 32'd0;
         r_uns           <= 1'b0;
         r_rm            <= 3'd0;
         r_sign          <= 1'b0;
         r_nan           <= 1'b0;
         r_inf           <= 1'b0;
         r_m             <= 24'd0;
         r_e             <= 10'sd0;
         r_big           <= 1'b0;
         r_int           <= 32'd0;
         r_g             <= 1'b0;
         r_s             <= 1'b0;
         r_res           <= 32'd0;
         r_nv            <= 1'b0;
         r_nx            <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         cvrt_to_int_out <= 32'd0;
         fflags_o        <= 5'd0;
      end else begin
         done_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_a     <= A_i;
                  r_uns   <= is_unsigned_i;
                  r_rm    <= rounding_mode_i;
                  r_state <= S_UNPACK;
                  busy_o  <= 1'b1;
               end
            end
            S_UNPACK: begin
               r_nan   <= (&r_a[30:23]) & (|r_a[22:0]);
               r_inf   <= (&r_a[30:23]) & ~(|r_a[22:0]);
               // NaN saturates like +Inf, so its sign is dropped here
               r_sign  <= r_a[31] & ~((&r_a[30:23]) & (|r_a[22:0]));
               r_m     <= {|r_a[30:23], r_a[22:0]};
               r_e     <= w_e;
               r_state <= S_ALIGN;
            end
            S_ALIGN: begin
               r_big <= 1'b0;
               if (r_nan || r_inf || r_e >= 10'sd32) begin
                  r_big <= 1'b1;
                  r_int <= 32'd0;
                  r_g   <= 1'b0;
                  r_s   <= 1'b0;
               end else if (r_e < -10'sd1) begin
                  r_int <= 32'd0;
                  r_g   <= 1'b0;
                  r_s   <= |r_m;
               end else begin
                  r_int <= w_t[55:24];
                  r_g   <= w_t[23];
                  r_s   <= |w_t[22:0];
               end
               r_state <= S_ROUND;
            end
            S_ROUND: begin
               r_res   <= w_res;
               r_nv    <= w_nv;
               r_nx    <= w_nx;
               busy_o  <= 1'b0;
               r_state <= S_DONE;
            end
            S_DONE: begin
               cvrt_to_int_out <= r_res;
               fflags_o        <= {r_nv, 3'b000, r_nx};
               done_o          <= 1'b1;
               if (start_i) begin
                  r_a     <= A_i;
                  r_uns   <= is_unsigned_i;
                  r_rm    <= rounding_mode_i;
                  r_state <= S_UNPACK;
                  busy_o  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fpu_cvt_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_cvt_to_int
//  Description : Directed self-checking bench for fpu_cvt_to_int.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_cvt_to_int;

   logic        clk;
   logic        rst;
   logic        start;
   logic        uns;
   logic [2:0]  rm;
   logic [31:0] a;
   logic        busy;
   logic        done;
   logic [31:0] res;
   logic [4:0]  flags;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] c_RNE = 3'd0;
   localparam logic [2:0] c_RTZ = 3'd1;
   localparam logic [2:0] c_RDN = 3'd2;
   localparam logic [2:0] c_RUP = 3'd3;
   localparam logic [2:0] c_RMM = 3'd4;
   localparam logic [4:0] c_NV  = 5'b10000;
   localparam logic [4:0] c_NX  = 5'b00001;

   fpu_cvt_to_int u_dut (
      .clk_i           (clk),
      .reset_i         (rst),
      .start_i         (start),
      .is_unsigned_i   (uns),
      .rounding_mode_i (rm),
      .A_i             (a),
      .busy_o          (busy),
      .done_o          (done),
      .cvrt_to_int_out (res),
      .fflags_o        (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request and wait (bounded) for done; checks latency, result and flags
   task automatic run_cvt(input string tag, input logic [31:0] op, input logic is_uns,
                          input logic [2:0] mode, input logic [31:0] exp_res, input logic [4:0] exp_fl);
      int k;
      @(negedge clk);
      a = op; uns = is_uns; rm = mode; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check_val({tag, " latency"}, k, 4);
      check_val({tag, " result"}, res, exp_res);
      check_val({tag, " flags"}, {27'd0, flags}, {27'd0, exp_fl});
   endtask

   initial begin
      int k;
      int pulses;
      rst = 1'b1; start = 1'b0; uns = 1'b0; rm = 3'd0; a = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset busy",   {31'd0, busy}, 32'd0);
      check_val("reset done",   {31'd0, done}, 32'd0);
      check_val("reset result", res, 32'd0);
      check_val("reset flags",  {27'd0, flags}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_cvt("2.5 RNE", 32'h4020_0000, 1'b0, c_RNE, 32'd2, c_NX);
      run_cvt("2.5 RTZ", 32'h4020_0000, 1'b0, c_RTZ, 32'd2, c_NX);
      run_cvt("2.5 RDN", 32'h4020_0000, 1'b0, c_RDN, 32'd2, c_NX);
      run_cvt("2.5 RUP", 32'h4020_0000, 1'b0, c_RUP, 32'd3, c_NX);
      run_cvt("2.5 RMM", 32'h4020_0000, 1'b0, c_RMM, 32'd3, c_NX);
      run_cvt("2.5 rm7", 32'h4020_0000, 1'b0, 3'd7,  32'd2, c_NX);
      run_cvt("-2.5 RNE", 32'hC020_0000, 1'b0, c_RNE, 32'hFFFF_FFFE, c_NX);
      run_cvt("-2.5 RDN", 32'hC020_0000, 1'b0, c_RDN, 32'hFFFF_FFFD, c_NX);
      run_cvt("-2.5 RUP", 32'hC020_0000, 1'b0, c_RUP, 32'hFFFF_FFFE, c_NX);
      run_cvt("3.5 RNE",  32'h4060_0000, 1'b0, c_RNE, 32'd4, c_NX);
      run_cvt("2^31 s",   32'h4F00_0000, 1'b0, c_RNE, 32'h7FFF_FFFF, c_NV);
      run_cvt("-2^31 s",  32'hCF00_0000, 1'b0, c_RNE, 32'h8000_0000, 5'd0);
      run_cvt("2^31 u",   32'h4F00_0000, 1'b1, c_RNE, 32'h8000_0000, 5'd0);
      run_cvt("2^32 u",   32'h4F80_0000, 1'b1, c_RNE, 32'hFFFF_FFFF, c_NV);
      run_cvt("NaN s",    32'h7FC0_0000, 1'b0, c_RNE, 32'h7FFF_FFFF, c_NV);
      run_cvt("NaN u",    32'h7FC0_0000, 1'b1, c_RNE, 32'hFFFF_FFFF, c_NV);
      run_cvt("-Inf s",   32'hFF80_0000, 1'b0, c_RNE, 32'h8000_0000, c_NV);
      run_cvt("-Inf u",   32'hFF80_0000, 1'b1, c_RNE, 32'd0, c_NV);
      run_cvt("-0.0",     32'h8000_0000, 1'b0, c_RNE, 32'd0, 5'd0);
      run_cvt("sub RUP",  32'h0000_0001, 1'b0, c_RUP, 32'd1, c_NX);
      run_cvt("-sub RDN", 32'h8000_0001, 1'b0, c_RDN, 32'hFFFF_FFFF, c_NX);
      run_cvt("sub RNE",  32'h0000_0001, 1'b0, c_RNE, 32'd0, c_NX);
      run_cvt("-0.5u RTZ", 32'hBF00_0000, 1'b1, c_RTZ, 32'd0, c_NX);
      run_cvt("-0.5u RDN", 32'hBF00_0000, 1'b1, c_RDN, 32'd0, c_NV);
      run_cvt("-1.0u",     32'hBF80_0000, 1'b1, c_RNE, 32'd0, c_NV);
      run_cvt("100.75 u",  32'h42C9_8000, 1'b1, c_RNE, 32'd101, c_NX);

      // start pulsed while busy is ignored
      @(negedge clk);
      a = 32'h4020_0000; uns = 1'b0; rm = c_RUP; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      k = 1;
      check_val("busy high", {31'd0, busy}, 32'd1);
      @(negedge clk);
      a = 32'h4040_0000; start = 1'b1;
      @(posedge clk); #1;
      k = 2;
      start = 1'b0;
      while (!done && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check_val("ignore latency", k, 4);
      check_val("ignore result", res, 32'd3);
      pulses = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check_val("ignore extra done", pulses, 0);

      // reset while in ALIGN
      @(negedge clk);
      a = 32'h4020_0000; rm = c_RNE; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("midrst busy",   {31'd0, busy}, 32'd0);
      check_val("midrst result", res, 32'd0);
      check_val("midrst flags",  {27'd0, flags}, 32'd0);
      pulses = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check_val("midrst done", pulses, 0);

      // start accepted in DONE for back-to-back operation
      @(negedge clk);
      a = 32'h4020_0000; uns = 1'b0; rm = c_RNE; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      a = 32'hC020_0000; rm = c_RNE; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_val("b2b first done",   {31'd0, done}, 32'd1);
      check_val("b2b first result", res, 32'd2);
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!done && k < 20);
      check_val("b2b latency", k, 4);
      check_val("b2b result", res, 32'hFFFF_FFFE);
      check_val("b2b flags", {27'd0, flags}, {27'd0, c_NX});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
